// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier datapath and its consumers.
// Provides the result width and the result word type.
package booth_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] result_t;

endpackage

// File: rtl/capture_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module capture_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_capture_fifo.sv
// Captures multiplier results into a show-ahead FIFO with halt and overflow.
// Ports: clk, reset_all, in_data/in_valid, halt, rd_*, count, overflow.
module result_capture_fifo
  import booth_pkg::*;
#(
  parameter int DATA_W            = booth_pkg::DATA_W,
  parameter int DEPTH             = 8,
  parameter int HALT_MARGIN       = 2,
  parameter bit CAPTURE_ON_CHANGE = 1'b0,
  parameter int AW                = $clog2(DEPTH),
  parameter int CW                = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_all,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              halt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HALT_CNT = CW'(DEPTH - HALT_MARGIN);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] last_cap;
  logic              first;
  logic              push_req;
  logic              pop;
  logic              push;
  logic              full;
  logic [CW-1:0]     count_next;

  always_comb begin
    push_req = in_valid;
    if (CAPTURE_ON_CHANGE) begin
      push_req = first || (in_data != last_cap);
    end
  end

  assign rd_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign pop      = rd_valid && rd_ready;
  // A full FIFO still accepts a push when the head leaves this cycle.
  assign push     = push_req && (!full || pop);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halt     <= 1'b0;
      overflow <= 1'b0;
      first    <= 1'b1;
      last_cap <= '0;
    end else begin
      count <= count_next;
      halt  <= (count_next >= HALT_CNT);
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        last_cap <= in_data;
        first    <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push && !reset_all),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_result_capture_fifo.sv
// Directed bench for result_capture_fifo: table vectors plus corner sequences.
// Second instance exercises capture-on-change.
module tb_result_capture_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        halt;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [3:0]  count;
  logic        overflow;

  logic        rst2;
  logic [15:0] in_data2;
  logic        in_valid2;
  logic        halt2;
  logic [15:0] rd_data2;
  logic        rd_valid2;
  logic        rd_ready2;
  logic [3:0]  count2;
  logic        overflow2;

  int checks = 0;
  int errors = 0;

  result_capture_fifo #(
    .DEPTH(8), .HALT_MARGIN(2), .CAPTURE_ON_CHANGE(1'b0)
  ) dut (
    .clk(clk), .reset_all(rst), .in_data(in_data),
    .in_valid(in_valid), .halt(halt), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count),
    .overflow(overflow)
  );

  result_capture_fifo #(
    .DEPTH(8), .HALT_MARGIN(2), .CAPTURE_ON_CHANGE(1'b1)
  ) dut2 (
    .clk(clk), .reset_all(rst2), .in_data(in_data2),
    .in_valid(in_valid2), .halt(halt2), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .rd_ready(rd_ready2), .count(count2),
    .overflow(overflow2)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic [3:0]  ec;
    logic        ev;
    logic [15:0] ed;
    logic        eh;
    logic        eo;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic v, logic [15:0] d, logic r,
                              logic [3:0] ec, logic ev,
                              logic [15:0] ed, logic eh, logic eo);
    vec_t t;
    t = '{v: v, d: d, r: r, ec: ec, ev: ev, ed: ed, eh: eh, eo: eo};
    vq.push_back(t);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; rd_ready = 1'b0;
    rst2 = 1'b1; in_data2 = '0; in_valid2 = 1'b0; rd_ready2 = 1'b0;
    step; step;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;

    // basic order
    add(1, 16'h0003, 0, 1, 1, 16'h0003, 0, 0);
    add(1, 16'h0005, 0, 2, 1, 16'h0003, 0, 0);
    add(1, 16'h000F, 0, 3, 1, 16'h0003, 0, 0);
    add(0, 16'h0000, 1, 2, 1, 16'h0005, 0, 0);
    add(0, 16'h0000, 1, 1, 1, 16'h000F, 0, 0);
    add(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0);
    // halt threshold
    add(1, 16'h0010, 0, 1, 1, 16'h0010, 0, 0);
    add(1, 16'h0011, 0, 2, 1, 16'h0010, 0, 0);
    add(1, 16'h0012, 0, 3, 1, 16'h0010, 0, 0);
    add(1, 16'h0013, 0, 4, 1, 16'h0010, 0, 0);
    add(1, 16'h0014, 0, 5, 1, 16'h0010, 0, 0);
    add(1, 16'h0015, 0, 6, 1, 16'h0010, 1, 0);
    add(0, 16'h0000, 1, 5, 1, 16'h0011, 0, 0);
    // fill, overflow, full push with pop
    add(1, 16'h0016, 0, 6, 1, 16'h0011, 1, 0);
    add(1, 16'h0017, 0, 7, 1, 16'h0011, 1, 0);
    add(1, 16'h0018, 0, 8, 1, 16'h0011, 1, 0);
    add(1, 16'hBEEF, 0, 8, 1, 16'h0011, 1, 1);
    add(1, 16'h1234, 1, 8, 1, 16'h0012, 1, 1);
    add(0, 16'h0000, 1, 7, 1, 16'h0013, 1, 1);
    add(0, 16'h0000, 1, 6, 1, 16'h0014, 1, 1);
    add(0, 16'h0000, 1, 5, 1, 16'h0015, 0, 1);
    add(0, 16'h0000, 1, 4, 1, 16'h0016, 0, 1);
    add(0, 16'h0000, 1, 3, 1, 16'h0017, 0, 1);
    add(0, 16'h0000, 1, 2, 1, 16'h0018, 0, 1);
    add(0, 16'h0000, 1, 1, 1, 16'h1234, 0, 1);
    add(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1);

    foreach (vq[i]) begin
      in_valid = vq[i].v;
      in_data  = vq[i].d;
      rd_ready = vq[i].r;
      step;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].ec));
      chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vq[i].ev));
      if (vq[i].ev) begin
        chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(vq[i].ed));
      end
      chk($sformatf("v%0d_halt", i), 32'(halt), 32'(vq[i].eh));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vq[i].eo));
    end

    // steady push+pop across pointer wrap
    in_valid = 1'b1; rd_ready = 1'b0;
    in_data = 16'hA000; step;
    in_data = 16'hA001; step;
    chk("wrap_pre_count", 32'(count), 2);
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 16'(16'hA002 + i);
      step;
      chk($sformatf("wrap%0d_count", i), 32'(count), 2);
      chk($sformatf("wrap%0d_data", i), 32'(rd_data),
          32'(16'hA001 + i));
    end

    // reach count 5 with overflow set, then reset mid-stream
    rd_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_data = 16'(16'hC000 + i);
      step;
    end
    chk("pre_rst_full", 32'(count), 8);
    chk("pre_rst_ovf", 32'(overflow), 1);
    in_valid = 1'b0; rd_ready = 1'b1;
    step; step; step;
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_ovf2", 32'(overflow), 1);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
    step;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(rd_valid), 0);
    chk("midrst_halt", 32'(halt), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    rst = 1'b0; in_valid = 1'b0; rd_ready = 1'b0;
    step;
    chk("postrst_count", 32'(count), 0);
    in_valid = 1'b1; in_data = 16'h4242;
    step;
    in_valid = 1'b0;
    chk("postrst_push_count", 32'(count), 1);
    chk("postrst_push_data", 32'(rd_data), 32'h4242);

    // capture on change
    rst2 = 1'b0; in_data2 = 16'h0000; in_valid2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk($sformatf("coc_zero%0d_count", i), 32'(count2), 1);
    end
    in_data2 = 16'h0015; in_valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("coc_15_%0d_count", i), 32'(count2), 2);
    end
    chk("coc_head0", 32'(rd_data2), 32'h0000);
    rd_ready2 = 1'b1;
    step;
    chk("coc_pop1_count", 32'(count2), 1);
    chk("coc_head1", 32'(rd_data2), 32'h0015);
    step;
    chk("coc_pop2_count", 32'(count2), 0);
    chk("coc_pop2_valid", 32'(rd_valid2), 0);
    chk("coc_ovf", 32'(overflow2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_capture_fifo.md
# result_capture_fifo

Downstream consumer of the Booth multiplier top level: samples the 16-bit `out` result bus, buffers the captured products in a small synchronous FIFO, and presents them to a host-side reader over a valid/ready handshake. Its registered `halt` output drives the multiplier's `HALT` input, so the processor stalls before results can be lost. Overflow is reported through a sticky flag.

## Interface
- `DATA_W`, 16: width of captured result, equal to the multiplier `out` bus.
- `DEPTH`, 8: FIFO entries; power of two, at least 4.
- `HALT_MARGIN`, 2: free entries left when `halt` asserts; range 1 to DEPTH-1.
- `CAPTURE_ON_CHANGE`, 0: 0 = capture on `in_valid`; 1 = capture whenever `in_data` differs from the last captured word (`in_valid` ignored).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_all`  in  1  reset, synchronous and active-high.
- `in_data`  in  DATA_W  result bus from the multiplier (`out`).
- `in_valid`  in  1  result strobe; one push per cycle when high.
- `halt`  out  1  back-pressure to the multiplier `HALT`.
- `rd_data`  out  DATA_W  FIFO head word.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  reader accepts the head word.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one word was dropped.

## Operation
- Push request `push_req`:
  - `CAPTURE_ON_CHANGE`=0: `in_valid`.
  - `CAPTURE_ON_CHANGE`=1: `in_data != last_cap`, or `first` is set.
  - `first` is set by reset and cleared by the first accepted push.
  - `last_cap` is updated only on an accepted push.
- Pop: `rd_valid && rd_ready`.
- Push accepted when `push_req && (count < DEPTH || pop)`. A push while full with a simultaneous pop is accepted.
- Push refused when `push_req` arrives while full with no pop. The word is dropped, `overflow` is set to 1, and the pointers and `last_cap` are unchanged.
- Occupancy update:
  - `count` += 1 on push only.
  - `count` -= 1 on pop only.
  - Unchanged when both or neither occur.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally.
- `rd_data` is a combinational read of `mem[rd_ptr]` (show-ahead). It is don't-care when `rd_valid`=0; the bench must not check it then.
- `rd_valid` = (`count` != 0).
- `halt` register: next value = (`count_next` >= DEPTH-HALT_MARGIN).
- `overflow` is cleared only by reset.
- Reset values: pointers 0, `count` 0, `rd_valid` 0, `halt` 0, `overflow` 0, `first` 1, `last_cap` 0. Memory contents are not reset.
- Reset mid-operation discards all buffered words. The reset cycle does not accept a push or a pop, even if the inputs request them.

## Timing
- Write to read latency is 1 cycle. A word pushed at edge N is on `rd_data` with `rd_valid`=1 after edge N.
- A pop at edge N exposes the next entry immediately after edge N.
- `halt` rises at the same edge that makes `count` reach DEPTH-HALT_MARGIN. It falls at the edge that takes `count` below that threshold.
- The multiplier sees `halt` one cycle after the threshold push. The HALT_MARGIN≥1 slack absorbs its one in-flight result.
- Capture on change: the comparison uses the current `in_data` against the registered `last_cap`. A new value is pushed at the first edge it is present.

## Structure
- Shared package `booth_pkg`: `DATA_W` constant (16) and the `result_t` typedef (logic [DATA_W-1:0]). The multiplier datapath uses the same package.
- One sub-module, `capture_ram`: DEPTH×DATA_W storage with a synchronous write port and an asynchronous read port.
- Pointers, count, halt logic and capture logic live in `result_capture_fifo`.

## Test plan
- Reset then push 0x0003, 0x0005, 0x000F with `rd_ready`=0 → `count`=3 and `rd_data`=0x0003. With `rd_ready`=1, pops return 0x0003, 0x0005, 0x000F in order, then `rd_valid`=0.
- DEPTH=8, HALT_MARGIN=2, push 6 words → `halt`=1 after the 6th edge. Pop 1 → `halt`=0 the following edge.
- Fill 8 words, then push 0xBEEF with no pop → `overflow`=1, `count`=8, and 0xBEEF is never read. Next, push 0x1234 with a simultaneous pop → `count` stays 8 and 0x1234 is read last.
- Run 20 cycles of simultaneous push and pop with incrementing data → `count` stays constant and order is preserved across pointer wrap-around.
- `CAPTURE_ON_CHANGE`=1, hold `in_data`=0x0000 for 5 cycles, then 0x0015 for 3 cycles, then 0x0015 again → exactly 2 words captured: 0x0000 (first-after-reset) and 0x0015.
- Assert `reset_all` with `count`=5 and `overflow`=1 while `in_valid`=1 → after the edge: `count`=0, `rd_valid`=0, `halt`=0, `overflow`=0, and no word captured.
